core_mem_arbiter: RTL and testbench
===================================

# core_mem_arbiter

Shares one Wishbone-style memory port between the instruction and data OBI-style interfaces of a processor core. It is used in single-memory builds, where `ENABLE_SECOND_MEMORY` is not defined. The block sits between the core wrapper and the Controller's `core_*` bus. It serializes requests with a 2-way round-robin on contention and returns responses as `rvalid` pulses to the owning requester.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, address width for both requesters and the bus.
- `DATA_WIDTH`, 32, data width; strobes are `DATA_WIDTH/8` bits.
- `TIMEOUT_CYCLES`, 256, bus-wait limit; used only with `ARB_TIMEOUT_EN`; must be ≥1.

Ports. One clock; reset is synchronous and active-high.
- `clk_core`  in  1  core clock; all state updates on its rising edge.
- `rst_core`  in  1  synchronous active-high reset.
- `instr_req_i`, `instr_we_i`  in  1  instruction request and write-enable.
- `instr_addr_i`, `instr_wdata_i`  in  ADDR/DATA  instruction address and write data.
- `instr_be_i`  in  DATA/8  instruction byte enables.
- `instr_gnt_o`, `instr_rvalid_o`, `instr_err_o`  out  1  instruction grant, response valid, and error.
- `instr_rdata_o`  out  DATA  instruction read data.
- `data_*`  same set as `instr_*`, for the data requester.
- `core_cyc`, `core_stb`, `core_we`  out  1  Wishbone cycle, strobe, and write.
- `core_wstrb`  out  DATA/8  Wishbone byte strobes.
- `core_addr`, `core_data_out`  out  ADDR/DATA  Wishbone address and write data.
- `core_data_in`  in  DATA  Wishbone read data.
- `core_ack`  in  1  Wishbone acknowledge.

## Operation
- FSM states: `ARB_IDLE`, `ARB_BUS`, `ARB_RESP`. Reset state is `ARB_IDLE`.
- **ARB_IDLE**
  - If any `*_req_i` is high, pick a winner.
  - The winner's `*_gnt_o` is driven combinationally high in the same cycle.
  - On that edge, latch addr, we, be, wdata and the owner ID, then go to `ARB_BUS`.
  - The loser's gnt stays low; it must hold its request.
- **Arbitration**
  - A single request wins outright.
  - When both request, the port not recorded in `last_grant` wins.
  - `last_grant` updates on every grant. Reset value is INSTR, so data wins the first contention.
- **ARB_BUS**
  - `core_cyc` = `core_stb` = 1, driven from the latched registers.
  - `core_wstrb` = latched be.
  - On `core_ack`: capture `core_data_in` (reads only; writes capture 0), err=0, go to `ARB_RESP`.
- **ARB_RESP**
  - Owner's `*_rvalid_o` = 1 for exactly one cycle, with registered rdata and err. This applies to both reads and writes.
  - Next state is `ARB_IDLE`. No grant is issued in this state.
- `core_ack` while `core_cyc` is 0 is ignored.
- `*_rdata_o` hold their last value outside rvalid.
- Reset mid-transaction: return to `ARB_IDLE`; `core_cyc` drops at the next edge; no rvalid is emitted.

## Timing
- Reset values:
  - All `core_*` outputs are 0.
  - All gnt, rvalid, and err outputs are 0.
  - rdata outputs are 0.
  - `last_grant` = INSTR.
- Latency, with `req` and `gnt` in cycle N:
  - `core_cyc` is high from N+1.
  - If `core_ack` arrives in cycle N+k (k≥1), `rvalid` is high in cycle N+k+1.
- Minimum occupancy is 3 cycles per access (IDLE, BUS, RESP). The next grant is no earlier than N+k+2.
- Back-to-back contention alternates owners strictly.
- `gnt` is combinational from `req` in `ARB_IDLE` only. There is no combinational path from `core_ack` to any output.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A counter of `$clog2(TIMEOUT_CYCLES+1)` bits clears on entry to `ARB_BUS` and increments each BUS cycle without ack.
  - When the counter reaches `TIMEOUT_CYCLES`, drop `core_cyc` and go to `ARB_RESP` with err=1 and rdata=0.
  - A late `core_ack` after the timeout is ignored.
  - An ack arriving in the same cycle as the timeout wins (normal completion).
- `ARB_TIMEOUT_EN` undefined: no counter; the arbiter waits indefinitely; `*_err_o` are constant 0.

## Structure
- Package `core_mem_arb_pkg`:
  - `typedef enum logic [1:0] arb_state_t` (`ARB_IDLE`, `ARB_BUS`, `ARB_RESP`).
  - `typedef enum logic arb_port_t` (`PORT_INSTR`, `PORT_DATA`).
- Sub-module `rr_arbiter2`: combinational 2-way round-robin pick from `req[1:0]` and `last_grant`, outputs a one-hot grant.

## Test plan
- Single instruction read: `instr_req` at addr 0x100, ack after 2 wait cycles with data 0xDEADBEEF → `instr_gnt` in cycle 0, `core_cyc` in cycles 1–3, `instr_rvalid` in cycle 4 with 0xDEADBEEF, err=0.
- Simultaneous requests after reset: data write to 0x2000 (be=0xF) plus instruction read of 0x0 → data is served first, then instruction. A second simultaneous pair is served instruction first, then data.
- Write response: data write of 0x12345678 with be=0x3 → `core_wstrb`=0x3, `core_we`=1, `data_rvalid` pulses once, `data_rdata`=0.
- Spurious ack: `core_ack` pulsed in `ARB_IDLE` → no rvalid and no state change.
- Reset mid-BUS: assert `rst_core` while `core_cyc`=1 → `core_cyc`=0 at the next edge, no rvalid, next contention grants data.
- With `ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, no ack → `core_cyc` drops after 4 BUS cycles, rvalid with err=1 and rdata=0. A late ack is ignored.

Source files
------------

// File: rtl/core_mem_arb_pkg.sv
// core_mem_arbiter shared types: FSM states and requester IDs.
// Imported by the arbiter top and its round-robin picker.
package core_mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUS  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } arb_port_t;

endpackage

// File: rtl/rr_arbiter2.sv
// 2-way round-robin picker; bit 0 = instr, bit 1 = data.
// Purely combinational, one-hot (or zero) grant.
module rr_arbiter2
  import core_mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  arb_port_t  last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req == 2'b11):
        gnt = (last_grant == PORT_INSTR) ? 2'b10 : 2'b01;
      (req == 2'b01): gnt = 2'b01;
      (req == 2'b10): gnt = 2'b10;
      default:        gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// Shares one Wishbone port between instr/data OBI requesters.
// Define ARB_TIMEOUT_EN to enable the bus-wait timeout.
module core_mem_arbiter
  import core_mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk_core,
  input  logic                    rst_core,
  input  logic                    instr_req_i,
  input  logic                    instr_we_i,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  input  logic [DATA_WIDTH-1:0]   instr_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] instr_be_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  output logic                    instr_err_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  input  logic                    data_we_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic                    data_err_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    core_cyc,
  output logic                    core_stb,
  output logic                    core_we,
  output logic [DATA_WIDTH/8-1:0] core_wstrb,
  output logic [ADDR_WIDTH-1:0]   core_addr,
  output logic [DATA_WIDTH-1:0]   core_data_out,
  input  logic [DATA_WIDTH-1:0]   core_data_in,
  input  logic                    core_ack
);

  localparam int BW = DATA_WIDTH / 8;

  if (TIMEOUT_CYCLES < 1) begin : g_to_chk
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  arb_state_t            state;
  arb_port_t             owner;
  arb_port_t             last_grant;
  logic [1:0]            req;
  logic [1:0]            arb_gnt;
  logic [1:0]            gnt;
  logic                  pick_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_i_q;
  logic [DATA_WIDTH-1:0] rdata_d_q;
  logic [DATA_WIDTH-1:0] rsp;
  logic [BW-1:0]         be_q;
  logic                  we_q;
  logic                  cyc_q;
  logic                  rv_i_q;
  logic                  rv_d_q;

  assign req = {data_req_i, instr_req_i};

  rr_arbiter2 u_rr (
    .req        (req),
    .last_grant (last_grant),
    .gnt        (arb_gnt)
  );

  // Grants only exist while idle; nothing else reaches gnt.
  assign gnt    = (state == ARB_IDLE) ? arb_gnt : 2'b00;
  assign pick_d = gnt[1];

  assign instr_gnt_o = gnt[0];
  assign data_gnt_o  = gnt[1];

  assign rsp = we_q ? '0 : core_data_in;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          err_q;

  assign cnt_nxt = cnt + CW'(1);
`endif

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state      <= ARB_IDLE;
      owner      <= PORT_INSTR;
      last_grant <= PORT_INSTR;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
      cyc_q      <= 1'b0;
      rv_i_q     <= 1'b0;
      rv_d_q     <= 1'b0;
      rdata_i_q  <= '0;
      rdata_d_q  <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt        <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (|gnt) begin
            owner      <= pick_d ? PORT_DATA : PORT_INSTR;
            last_grant <= pick_d ? PORT_DATA : PORT_INSTR;
            addr_q     <= pick_d ? data_addr_i  : instr_addr_i;
            wdata_q    <= pick_d ? data_wdata_i : instr_wdata_i;
            be_q       <= pick_d ? data_be_i    : instr_be_i;
            we_q       <= pick_d ? data_we_i    : instr_we_i;
            cyc_q      <= 1'b1;
            state      <= ARB_BUS;
`ifdef ARB_TIMEOUT_EN
            cnt        <= '0;
`endif
          end
        end
        ARB_BUS: begin
          if (core_ack) begin
            cyc_q <= 1'b0;
            state <= ARB_RESP;
            if (owner == PORT_DATA) begin
              rdata_d_q <= rsp;
              rv_d_q    <= 1'b1;
            end else begin
              rdata_i_q <= rsp;
              rv_i_q    <= 1'b1;
            end
`ifdef ARB_TIMEOUT_EN
            err_q <= 1'b0;
          end else if (cnt_nxt == TO_LIM) begin
            // Abandon the cycle; a later ack lands outside BUS.
            cyc_q <= 1'b0;
            state <= ARB_RESP;
            err_q <= 1'b1;
            if (owner == PORT_DATA) begin
              rdata_d_q <= '0;
              rv_d_q    <= 1'b1;
            end else begin
              rdata_i_q <= '0;
              rv_i_q    <= 1'b1;
            end
          end else begin
            cnt <= cnt_nxt;
`endif
          end
        end
        ARB_RESP: begin
          rv_i_q <= 1'b0;
          rv_d_q <= 1'b0;
          state  <= ARB_IDLE;
`ifdef ARB_TIMEOUT_EN
          err_q  <= 1'b0;
`endif
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign core_cyc      = cyc_q;
  assign core_stb      = cyc_q;
  assign core_we       = we_q;
  assign core_wstrb    = be_q;
  assign core_addr     = addr_q;
  assign core_data_out = wdata_q;

  assign instr_rvalid_o = rv_i_q;
  assign data_rvalid_o  = rv_d_q;
  assign instr_rdata_o  = rdata_i_q;
  assign data_rdata_o   = rdata_d_q;

`ifdef ARB_TIMEOUT_EN
  assign instr_err_o = rv_i_q & err_q;
  assign data_err_o  = rv_d_q & err_q;
`else
  assign instr_err_o = 1'b0;
  assign data_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter; timeout cases
// run when ARB_TIMEOUT_EN is defined (TIMEOUT_CYCLES=4).
module tb_core_mem_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 256;
`endif

  logic        clk_core = 1'b0;
  logic        rst_core = 1'b1;
  logic        instr_req_i = 1'b0;
  logic        instr_we_i = 1'b0;
  logic [31:0] instr_addr_i = '0;
  logic [31:0] instr_wdata_i = '0;
  logic [3:0]  instr_be_i = '0;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic        instr_err_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i = 1'b0;
  logic        data_we_i = 1'b0;
  logic [31:0] data_addr_i = '0;
  logic [31:0] data_wdata_i = '0;
  logic [3:0]  data_be_i = '0;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic        data_err_o;
  logic [31:0] data_rdata_o;
  logic        core_cyc;
  logic        core_stb;
  logic        core_we;
  logic [3:0]  core_wstrb;
  logic [31:0] core_addr;
  logic [31:0] core_data_out;
  logic [31:0] core_data_in = '0;
  logic        core_ack = 1'b0;

  int checks = 0;
  int fails  = 0;

  core_mem_arbiter #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_core       (clk_core),
    .rst_core       (rst_core),
    .instr_req_i    (instr_req_i),
    .instr_we_i     (instr_we_i),
    .instr_addr_i   (instr_addr_i),
    .instr_wdata_i  (instr_wdata_i),
    .instr_be_i     (instr_be_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_err_o    (instr_err_o),
    .instr_rdata_o  (instr_rdata_o),
    .data_req_i     (data_req_i),
    .data_we_i      (data_we_i),
    .data_addr_i    (data_addr_i),
    .data_wdata_i   (data_wdata_i),
    .data_be_i      (data_be_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_err_o     (data_err_o),
    .data_rdata_o   (data_rdata_o),
    .core_cyc       (core_cyc),
    .core_stb       (core_stb),
    .core_we        (core_we),
    .core_wstrb     (core_wstrb),
    .core_addr      (core_addr),
    .core_data_out  (core_data_out),
    .core_data_in   (core_data_in),
    .core_ack       (core_ack)
  );

  always #5 clk_core = ~clk_core;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic nx();
    @(negedge clk_core);
  endtask

  initial begin
    // reset state
    nx(); nx();
    rst_core = 1'b0;
    #1;
    chk("rst_cyc", {core_cyc, core_stb, core_we}, 0);
    chk("rst_addr", core_addr, 0);
    chk("rst_wdat", core_data_out, 0);
    chk("rst_strb", core_wstrb, 0);
    chk("rst_gnt", {instr_gnt_o, data_gnt_o}, 0);
    chk("rst_rv", {instr_rvalid_o, data_rvalid_o}, 0);
    chk("rst_err", {instr_err_o, data_err_o}, 0);
    chk("rst_irdata", instr_rdata_o, 0);
    chk("rst_drdata", data_rdata_o, 0);

    // single instr read, ack after 2 wait cycles
    nx();
    instr_req_i = 1; instr_addr_i = 32'h100;
    instr_we_i = 0; instr_be_i = 4'hF;
    #1;
    chk("rd_ignt_c0", instr_gnt_o, 1);
    chk("rd_dgnt_c0", data_gnt_o, 0);
    nx(); instr_req_i = 0; #1;
    chk("rd_cyc_c1", {core_cyc, core_stb}, 2'b11);
    chk("rd_addr", core_addr, 32'h100);
    chk("rd_we", core_we, 0);
    nx(); #1;
    chk("rd_cyc_c2", core_cyc, 1);
    nx(); core_ack = 1; core_data_in = 32'hDEADBEEF; #1;
    chk("rd_cyc_c3", core_cyc, 1);
    chk("rd_rv_c3", instr_rvalid_o, 0);
    nx(); core_ack = 0; #1;
    chk("rd_rv_c4", instr_rvalid_o, 1);
    chk("rd_rdata", instr_rdata_o, 32'hDEADBEEF);
    chk("rd_err", instr_err_o, 0);
    chk("rd_cyc_c4", core_cyc, 0);
    chk("rd_drv_c4", data_rvalid_o, 0);
    nx(); #1;
    chk("rd_rv_c5", instr_rvalid_o, 0);
    chk("rd_hold", instr_rdata_o, 32'hDEADBEEF);

    // contention after reset: data, instr, data
    rst_core = 1; nx(); rst_core = 0;
    data_req_i = 1; data_we_i = 1; data_addr_i = 32'h2000;
    data_be_i = 4'hF; data_wdata_i = 32'hA5A5A5A5;
    instr_req_i = 1; instr_addr_i = 32'h0;
    #1;
    chk("ct1_dgnt", data_gnt_o, 1);
    chk("ct1_ignt", instr_gnt_o, 0);
    nx();
    data_addr_i = 32'h2004; data_wdata_i = 32'h5A5A0001;
    #1;
    chk("ct1_addr", core_addr, 32'h2000);
    chk("ct1_we", core_we, 1);
    chk("ct1_strb", core_wstrb, 4'hF);
    chk("ct1_wdat", core_data_out, 32'hA5A5A5A5);
    chk("ct1_busgnt", {instr_gnt_o, data_gnt_o}, 0);
    core_ack = 1; core_data_in = 32'h11111111;
    nx(); core_ack = 0; #1;
    chk("ct1_drv", data_rvalid_o, 1);
    chk("ct1_drdat", data_rdata_o, 0);
    chk("ct1_respgnt", {instr_gnt_o, data_gnt_o}, 0);
    nx(); #1;
    chk("ct2_ignt", instr_gnt_o, 1);
    chk("ct2_dgnt", data_gnt_o, 0);
    nx(); instr_req_i = 0; #1;
    chk("ct2_addr", core_addr, 32'h0);
    chk("ct2_we", core_we, 0);
    core_ack = 1; core_data_in = 32'hCAFEF00D;
    nx(); core_ack = 0; #1;
    chk("ct2_irv", instr_rvalid_o, 1);
    chk("ct2_irdat", instr_rdata_o, 32'hCAFEF00D);
    chk("ct2_dhold", data_rdata_o, 0);
    nx(); #1;
    chk("ct3_dgnt", data_gnt_o, 1);
    nx(); data_req_i = 0; #1;
    chk("ct3_addr", core_addr, 32'h2004);
    chk("ct3_wdat", core_data_out, 32'h5A5A0001);
    core_ack = 1;
    nx(); core_ack = 0; #1;
    chk("ct3_drv", data_rvalid_o, 1);
    nx(); #1;

    // partial-strobe write
    data_req_i = 1; data_we_i = 1; data_addr_i = 32'h3000;
    data_be_i = 4'h3; data_wdata_i = 32'h12345678;
    #1;
    chk("wr_dgnt", data_gnt_o, 1);
    nx(); data_req_i = 0; #1;
    chk("wr_strb", core_wstrb, 4'h3);
    chk("wr_we", core_we, 1);
    chk("wr_wdat", core_data_out, 32'h12345678);
    core_ack = 1; core_data_in = 32'hFFFFFFFF;
    nx(); core_ack = 0; #1;
    chk("wr_drv", data_rvalid_o, 1);
    chk("wr_drdat", data_rdata_o, 0);
    nx(); #1;
    chk("wr_drv_once", data_rvalid_o, 0);

    // spurious ack while idle
    core_ack = 1; core_data_in = 32'hBAD0BAD0;
    nx(); core_ack = 0; #1;
    chk("sp_rv", {instr_rvalid_o, data_rvalid_o}, 0);
    chk("sp_cyc", core_cyc, 0);
    nx(); #1;
    chk("sp_rv2", {instr_rvalid_o, data_rvalid_o}, 0);
    chk("sp_ihold", instr_rdata_o, 32'hCAFEF00D);
    instr_req_i = 1; instr_addr_i = 32'h40; #1;
    chk("sp_idle_gnt", instr_gnt_o, 1);
    nx(); instr_req_i = 0;
    core_ack = 1; core_data_in = 32'h0BADCAFE;
    nx(); core_ack = 0; #1;
    chk("sp_irdat", instr_rdata_o, 32'h0BADCAFE);
    nx(); #1;

    // reset mid-BUS restores last_grant to INSTR
    data_req_i = 1; data_we_i = 0; data_addr_i = 32'h4000;
    nx(); data_req_i = 0; #1;
    chk("rb_cyc", core_cyc, 1);
    rst_core = 1;
    nx(); rst_core = 0; #1;
    chk("rb_cyc0", core_cyc, 0);
    chk("rb_rv", {instr_rvalid_o, data_rvalid_o}, 0);
    chk("rb_addr", core_addr, 0);
    data_req_i = 1; instr_req_i = 1; #1;
    chk("rb_dgnt", data_gnt_o, 1);
    chk("rb_ignt", instr_gnt_o, 0);
    nx(); data_req_i = 0; instr_req_i = 0;
    core_ack = 1; core_data_in = 32'h00000077;
    nx(); core_ack = 0; #1;
    chk("rb_drv", data_rvalid_o, 1);
    chk("rb_drdat", data_rdata_o, 32'h77);
    nx(); #1;

`ifdef ARB_TIMEOUT_EN
    // no ack: cycle abandoned after TO bus cycles
    instr_req_i = 1; instr_addr_i = 32'h500; instr_we_i = 0; #1;
    chk("to_ignt", instr_gnt_o, 1);
    for (int i = 1; i <= TO; i++) begin
      nx(); instr_req_i = 0; #1;
      chk($sformatf("to_cyc%0d", i), core_cyc, 1);
    end
    nx(); #1;
    chk("to_cyc_drop", core_cyc, 0);
    chk("to_irv", instr_rvalid_o, 1);
    chk("to_err", instr_err_o, 1);
    chk("to_rdat", instr_rdata_o, 0);
    core_ack = 1; core_data_in = 32'h99999999;
    nx(); core_ack = 0; #1;
    chk("to_late_rv", instr_rvalid_o, 0);
    chk("to_late_err", instr_err_o, 0);
    chk("to_late_cyc", core_cyc, 0);
    nx(); #1;
    chk("to_late_rv2", instr_rvalid_o, 0);
    chk("to_late_rdat", instr_rdata_o, 0);
    // ack in the timeout cycle completes normally
    instr_req_i = 1; #1;
    for (int i = 1; i < TO; i++) begin
      nx(); instr_req_i = 0;
    end
    nx(); core_ack = 1; core_data_in = 32'h44444444;
    nx(); core_ack = 0; #1;
    chk("tie_irv", instr_rvalid_o, 1);
    chk("tie_err", instr_err_o, 0);
    chk("tie_rdat", instr_rdata_o, 32'h44444444);
    nx(); #1;
`else
    // no timeout: bus wait is unbounded
    instr_req_i = 1; instr_addr_i = 32'h500; instr_we_i = 0; #1;
    chk("nt_ignt", instr_gnt_o, 1);
    for (int i = 0; i < 10; i++) begin
      nx(); instr_req_i = 0;
    end
    #1;
    chk("nt_cyc", core_cyc, 1);
    chk("nt_rv", instr_rvalid_o, 0);
    core_ack = 1; core_data_in = 32'h55AA55AA;
    nx(); core_ack = 0; #1;
    chk("nt_irv", instr_rvalid_o, 1);
    chk("nt_err", instr_err_o, 0);
    chk("nt_rdat", instr_rdata_o, 32'h55AA55AA);
    nx(); #1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
